// File: rtl/sig_pkg.sv
// Shared definitions for the signature table loader: FSM states and error codes.
package sig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;

  // Error code for a beat that ends the load, from "s_last seen" and
  // "this beat filled the last table slot".
  function automatic logic [1:0] end_code(input logic is_last, input logic is_final);
    logic [1:0] code;
    if (is_last && is_final) begin
      code = ERR_NONE;
    end else if (is_last) begin
      code = ERR_SHORT;
    end else begin
      code = ERR_LONG;
    end
    return code;
  endfunction

endpackage

// File: rtl/sig_rom_loader.sv
// Streams table entries from a valid/ready source into a table RAM.
// Entry k goes to address k: the reader indexes by offset-binary of the signed
// input x = k - 2**(inWidth-1), and offset-binary(x) == k.
// Flags short/long loads and non-monotonic (descending) data.
module sig_rom_loader
  import sig_pkg::*;
#(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_last,
  output logic                 wr_en,
  output logic [inWidth-1:0]   wr_addr,
  output logic [dataWidth-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err,
  output logic                 mono_err,
  output logic [inWidth:0]     count
);

  // Index of the final table slot, widened to the counter width.
  localparam logic [inWidth:0] LAST_K  = {1'b0, {inWidth{1'b1}}};
  localparam logic [inWidth:0] ONE_K   = {{inWidth{1'b0}}, 1'b1};
  localparam logic [inWidth:0] ZERO_K  = {(inWidth+1){1'b0}};

  state_t               r_state;
  logic                 r_wr_en;
  logic [inWidth-1:0]   r_wr_addr;
  logic [dataWidth-1:0] r_wr_data;
  logic [1:0]           r_err;
  logic                 r_mono_err;
  logic [inWidth:0]     r_count;

  logic w_beat;
  logic w_final;

  // s_ready depends on state alone so upstream never sees a combinational loop.
  assign s_ready  = (r_state == ST_LOAD);
  assign busy     = (r_state == ST_LOAD);
  assign done     = (r_state == ST_DONE);
  assign w_beat   = s_valid & (r_state == ST_LOAD);
  assign w_final  = (r_count == LAST_K);

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign err      = r_err;
  assign mono_err = r_mono_err;
  assign count    = r_count;

  // Load FSM: accepts beats, issues one-cycle-late writes, tracks errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= {inWidth{1'b0}};
      r_wr_data  <= {dataWidth{1'b0}};
      r_err      <= ERR_NONE;
      r_mono_err <= 1'b0;
      r_count    <= ZERO_K;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_beat) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_count[inWidth-1:0];
            r_wr_data <= s_data;
            r_count   <= r_count + ONE_K;
            // r_wr_data still holds the previous accepted entry here.
            if ((r_count != ZERO_K) && (s_data < r_wr_data)) begin
              r_mono_err <= 1'b1;
            end
            if (s_last || w_final) begin
              r_state <= (s_last && w_final) ? ST_DONE : ST_ERROR;
              r_err   <= end_code(s_last, w_final);
            end
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_count    <= ZERO_K;
            r_err      <= ERR_NONE;
            r_mono_err <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sig_rom_loader.md
SIG_ROM_LOADER -- requirements
Module: sig_rom_loader

Interface
REQ-001 SHALL have parameter inWidth, default 10, meaning the table address width (table depth 2**inWidth).
REQ-002 SHALL have parameter dataWidth, default 16, meaning the table entry width.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a table load.
REQ-006 s_valid  input  1  upstream entry valid.
REQ-007 s_ready  output  1  loader can accept an entry.
REQ-008 s_data  input  dataWidth  table entry, unsigned.
REQ-009 s_last  input  1  marks the final entry of the load.
REQ-010 wr_en  output  1  write strobe to table RAM.
REQ-011 wr_addr  output  inWidth  table RAM write address.
REQ-012 wr_data  output  dataWidth  table RAM write data.
REQ-013 busy  output  1  high while in LOAD.
REQ-014 done  output  1  high while in DONE.
REQ-015 err  output  2  error code: 0 none, 1 SHORT (s_last early), 2 LONG (final entry without s_last).
REQ-016 mono_err  output  1  sticky flag: an entry was less than its predecessor.
REQ-017 count  output  inWidth+1  number of entries accepted in the current/last load.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE, ERROR.
REQ-019 start in IDLE, DONE or ERROR -> LOAD next cycle; count, err, mono_err cleared; start while in LOAD ignored.
REQ-020 s_ready SHALL equal 1 exactly when state is LOAD, combinational from state only.
REQ-021 Beat accepted when s_valid & s_ready; s_data, s_last ignored otherwise.
REQ-022 Accepted beat k (0-based) SHALL produce wr_en=1, wr_addr=k, wr_data=s_data on the following cycle (latency 1, registered); wr_en=0 on all other cycles.
REQ-023 Entry k SHALL represent signed input x = k - 2**(inWidth-1), so wr_addr is offset-binary x (x with MSB inverted), matching the table reader's index mapping.
REQ-024 count SHALL increment by 1 per accepted beat, saturating never (load ends by 2**inWidth).
REQ-025 Beat with s_last and k == 2**inWidth-1 -> DONE, err=0.
REQ-026 Beat with s_last and k < 2**inWidth-1 -> ERROR, err=1; that beat is still written.
REQ-027 Beat with k == 2**inWidth-1 and s_last=0 -> ERROR, err=2; that beat is still written.
REQ-028 For k >= 1, accepted s_data < previous accepted s_data (unsigned) SHALL set mono_err; load continues.
REQ-029 DONE and ERROR SHALL hold (outputs stable, s_ready=0) until start or reset.
REQ-030 Simultaneous start and s_valid in IDLE: start wins, no beat accepted that cycle.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, mono_err=0, count=0.
REQ-032 Reset mid-LOAD SHALL abandon the load with no further writes; the pending registered write is dropped.

Structure
REQ-033 State enumeration and err code constants SHALL live in shared package sig_pkg.
REQ-034 Single flat module; no sub-module required.

Verification
REQ-035 start, 1024 beats data=k, s_last on k=1023, s_valid always 1 -> 1024 writes addr 0..1023, done=1, err=0, count=1024, mono_err=0.
REQ-036 start, 300 beats, s_last on k=299 -> ERROR, err=1, count=300, last write addr=299.
REQ-037 start, 1024 beats, no s_last -> ERROR, err=2, count=1024, s_ready=0 afterwards.
REQ-038 Full load with data 5 at k=512 and 4 at k=513 -> mono_err=1, done=1, err=0.
REQ-039 s_valid toggled 1/0 every cycle during full load -> exactly 1024 writes, addresses contiguous, each one cycle after acceptance.
REQ-040 rst_n low after 100 beats -> immediate IDLE, all outputs zero, no wr_en after reset asserted; new start then reloads from addr 0.
